// File: rtl/stream_width_packer_pkg.sv
// Purpose : shared types and helpers for the narrow-to-wide stream packer.
// Contents: FSM state enum and a constant-foldable ceiling-log2 helper.
// Ports   : none (package).
package packer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        PUSH = 1'b1
    } state_t;

    // Smallest r with 2**r >= n; used to size counters holding 0..RATIO.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_width_packer_if.sv
// Purpose : bundles the upstream dequeue side and downstream enqueue side of the packer.
// Ports   : in_rdy/in_en/in_val (narrow FIFO), out_rdy/out_en/out_val (wide FIFO), fill_cnt status;
//           flush/out_cnt exist only when PACKER_FLUSH_EN is defined. master = packer, slave = environment.
interface stream_width_packer_if #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
);
    import packer_pkg::*;

    localparam int CNT_W = clog2(RATIO + 1);

    logic                     in_rdy;
    logic                     in_en;
    logic [WIDTH-1:0]         in_val;
    logic                     out_rdy;
    logic                     out_en;
    logic [WIDTH*RATIO-1:0]   out_val;
    logic [CNT_W-1:0]         fill_cnt;
`ifdef PACKER_FLUSH_EN
    logic                     flush;
    logic [CNT_W-1:0]         out_cnt;

    modport master (
        input  in_rdy, in_val, out_rdy, flush,
        output in_en, out_en, out_val, fill_cnt, out_cnt
    );
    modport slave (
        output in_rdy, in_val, out_rdy, flush,
        input  in_en, out_en, out_val, fill_cnt, out_cnt
    );
`else
    modport master (
        input  in_rdy, in_val, out_rdy,
        output in_en, out_en, out_val, fill_cnt
    );
    modport slave (
        output in_rdy, in_val, out_rdy,
        input  in_en, out_en, out_val, fill_cnt
    );
`endif

endinterface

// File: rtl/stream_width_packer.sv
// Purpose : packs RATIO consecutive WIDTH-bit words into one WIDTH*RATIO-bit word, slot 0 in the LSBs.
// Latency : out_en no earlier than 1 cycle after the last word is taken; at least RATIO+1 cycles per output.
// Backpr. : out_rdy=0 holds PUSH with out_val/fill_cnt frozen; in_rdy=0 simply stalls filling.
// Ports   : clk, rst_n (synchronous, active-low), io (stream_width_packer_if.master).
// Config  : PACKER_FLUSH_EN adds flush (emit partial word) and out_cnt (valid slots in out_val).
module stream_width_packer
    import packer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    stream_width_packer_if.master io
);

    localparam int CNT_W = clog2(RATIO + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RATIO);

    state_t                       state;
    logic [CNT_W-1:0]             fill_q;
    logic [CNT_W-1:0]             fill_nxt;
    logic [RATIO-1:0][WIDTH-1:0]  slot_q;
    logic [RATIO-1:0]             slot_we;
    logic                         wr;
    logic                         rd;
    logic                         go_push;

    // Strobes are gated by rst_n so nothing transfers in a reset cycle.
    assign wr = rst_n & (state == FILL) & io.in_rdy;
    assign rd = rst_n & (state == PUSH) & io.out_rdy;

    assign io.in_en    = wr;
    assign io.out_en   = rd;
    assign io.out_val  = slot_q;
    assign io.fill_cnt = fill_q;

    assign fill_nxt = fill_q + CNT_W'(1);

`ifdef PACKER_FLUSH_EN
    logic [CNT_W-1:0] out_cnt_q;

    // A flush only counts if something will be held after this edge:
    // either slots are already occupied or a word is landing right now.
    assign go_push = (state == FILL) &
                     ((wr & (fill_nxt == FULL)) |
                      (io.flush & (wr | (fill_q != '0))));
    assign io.out_cnt = out_cnt_q;
`else
    assign go_push = wr & (fill_nxt == FULL);
`endif

    // Slot write decode: only the slot addressed by the current fill count takes the word.
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slot_we
        assign slot_we[gi] = wr & (fill_q == CNT_W'(gi));
    end

    // Slots are cleared on emission so unused slots of the next word read 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else if (rd) begin
            slot_q <= '0;
        end else begin
            for (int i = 0; i < RATIO; i++) begin
                if (slot_we[i]) begin
                    slot_q[i] <= io.in_val;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= FILL;
            fill_q <= '0;
`ifdef PACKER_FLUSH_EN
            out_cnt_q <= '0;
`endif
        end else begin
            case (state)
                FILL: begin
                    if (wr) begin
                        fill_q <= fill_nxt;
                    end
                    if (go_push) begin
                        state <= PUSH;
`ifdef PACKER_FLUSH_EN
                        out_cnt_q <= wr ? fill_nxt : fill_q;
`endif
                    end
                end
                PUSH: begin
                    if (rd) begin
                        state  <= FILL;
                        fill_q <= '0;
                    end
                end
                default: begin
                    state  <= FILL;
                    fill_q <= '0;
                end
            endcase
        end
    end

endmodule
